// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
// Holds the FSM encoding, the ID width helper and the round-robin picker.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam int MAX_CH = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First asserted request after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(
        input logic [MAX_CH-1:0] req,
        input logic [3:0]        ptr,
        input int                n
    );
        pick_t p;
        int    k;
        p = '0;
        for (int i = 1; i <= MAX_CH; i++) begin
            if (i <= n && !p.found) begin
                k = (int'(ptr) + i) % n;
                if (req[k[3:0]]) begin
                    p.found = 1'b1;
                    p.idx   = k[3:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tri_buffer_n.sv
// Per-bit tri-state driver for the shared data bus.
// Purely combinational; the enable comes registered from the arbiter.
module tri_buffer_n #(
    parameter int WIDTH = 32
) (
    input  logic             i_oe,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_out
);

    // Drive the bus only while a channel owns it.
    assign o_out = i_oe ? i_in : {WIDTH{1'bz}};

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter granting NUM_CH channels a shared tri-state bus.
// Optional tenure limit enabled by defining TRI_ARB_TIMEOUT_EN.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_CH      = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_BURST   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH*WIDTH-1:0]   data_in,
    output logic [NUM_CH-1:0]         grant,
    output logic [WIDTH-1:0]          bus_out,
    output logic                      bus_busy,
    output logic [id_w(NUM_CH)-1:0]   owner_id
);

    localparam int ID_W = id_w(NUM_CH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NUM_CH-1:0] r_grant;
    logic [NUM_CH-1:0] w_grant_nxt;
    logic [ID_W-1:0]   r_owner;
    logic [ID_W-1:0]   w_owner_nxt;
    logic [3:0]        r_ptr;
    logic [3:0]        w_ptr_nxt;
    logic [2:0]        r_turn;
    logic [2:0]        w_turn_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              w_take;
    logic              w_force;
    logic [MAX_CH-1:0] w_req16;
    pick_t             w_pick;
    logic [WIDTH-1:0]  w_data;

`ifdef TRI_ARB_TIMEOUT_EN
    localparam int TEN_W = $clog2(MAX_BURST + 1);
    logic [TEN_W-1:0] r_ten;
    logic [TEN_W-1:0] w_ten_nxt;
    logic [TEN_W-1:0] w_ten_inc;

    // Saturating tenure count; forces release only when others wait.
    always_comb begin
        w_ten_inc = (r_ten == TEN_W'(MAX_BURST)) ? r_ten : r_ten + 1'b1;
        w_force   = (w_ten_inc == TEN_W'(MAX_BURST)) && |(req & ~r_grant);
    end
`else
    assign w_force = 1'b0;
`endif

    // Widen requests to the picker's fixed width and choose the winner.
    always_comb begin
        w_req16             = '0;
        w_req16[NUM_CH-1:0] = req;
        w_pick              = rr_pick(w_req16, r_ptr, NUM_CH);
    end

    // Next-state and registered-output logic of the ownership FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_turn_nxt  = r_turn;
        w_busy_nxt  = r_busy;
        w_take      = 1'b0;
`ifdef TRI_ARB_TIMEOUT_EN
        w_ten_nxt   = r_ten;
`endif
        unique case (r_state)
            IDLE: begin
                w_take     = w_pick.found;
                w_busy_nxt = 1'b0;
            end
            OWN: begin
                if (!req[r_owner] || w_force) begin
                    w_state_nxt = TURN;
                    w_grant_nxt = '0;
                    w_owner_nxt = '0;
                    w_turn_nxt  = 3'(TURN_CYCLES - 1);
                    w_busy_nxt  = 1'b1;
                end
`ifdef TRI_ARB_TIMEOUT_EN
                else begin
                    w_ten_nxt = w_ten_inc;
                end
`endif
            end
            TURN: begin
                if (r_turn != 3'd0) begin
                    w_turn_nxt = r_turn - 3'd1;
                end else if (w_pick.found) begin
                    w_take = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
        if (w_take) begin
            w_state_nxt = OWN;
            w_grant_nxt = {{(NUM_CH-1){1'b0}}, 1'b1} << w_pick.idx;
            w_owner_nxt = w_pick.idx[ID_W-1:0];
            w_ptr_nxt   = w_pick.idx;
            w_busy_nxt  = 1'b1;
`ifdef TRI_ARB_TIMEOUT_EN
            w_ten_nxt   = '0;
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= 4'(NUM_CH - 1);
            r_turn  <= '0;
            r_busy  <= 1'b0;
`ifdef TRI_ARB_TIMEOUT_EN
            r_ten   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_turn  <= w_turn_nxt;
            r_busy  <= w_busy_nxt;
`ifdef TRI_ARB_TIMEOUT_EN
            r_ten   <= w_ten_nxt;
`endif
        end
    end

    // Owner data is steered combinationally; only the enable is registered.
    assign w_data = data_in[int'(r_owner)*WIDTH +: WIDTH];

    tri_buffer_n #(
        .WIDTH (WIDTH)
    ) u_buf (
        .i_oe  (|r_grant),
        .i_in  (w_data),
        .o_out (bus_out)
    );

    assign grant    = r_grant;
    assign owner_id = r_owner;
    assign bus_busy = r_busy;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter: vector table plus corner sequences.
// A second instance covers TURN_CYCLES=3; timeout runs when the macro is set.
module tb_tri_bus_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   req3;
    logic [127:0] data_in;
    logic [3:0]   grant;
    logic [3:0]   grant3;
    wire  [31:0]  bus_out;
    wire  [31:0]  bus_out3;
    logic         busy;
    logic         busy3;
    logic [1:0]   oid;
    logic [1:0]   oid3;

    int total = 0;
    int bad   = 0;

    logic [31:0] dv [4];

    always #5 clock = ~clock;

    tri_bus_arbiter #(
        .WIDTH(32), .NUM_CH(4), .TURN_CYCLES(1), .MAX_BURST(4)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .data_in(data_in),
        .grant(grant), .bus_out(bus_out), .bus_busy(busy), .owner_id(oid)
    );

    tri_bus_arbiter #(
        .WIDTH(32), .NUM_CH(4), .TURN_CYCLES(3), .MAX_BURST(16)
    ) dut3 (
        .clock(clock), .reset(reset), .req(req3), .data_in(data_in),
        .grant(grant3), .bus_out(bus_out3), .bus_busy(busy3),
        .owner_id(oid3)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    // A released bus reads as z, or as 0 on two-state simulators;
    // all channel data is nonzero so a driven bus is always visible.
    task automatic chk_z(input string nm, input logic [31:0] got);
        total++;
        if (got !== {32{1'bz}} && got !== 32'h0) begin
            bad++;
            $display("FAIL %s got=%h want=zzzzzzzz", nm, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        total++;
        if (!$onehot0(grant) || !$onehot0(grant3)) begin
            bad++;
            $display("FAIL onehot0 got=%b/%b want=onehot0", grant, grant3);
        end
    endtask

    initial begin
        dv[0] = 32'hC0DE0001;
        dv[1] = 32'h12345678;
        dv[2] = 32'hDEADBEEF;
        dv[3] = 32'h3333CAFE;
        data_in = {dv[3], dv[2], dv[1], dv[0]};
        reset = 1'b0;
        req   = 4'b0000;
        req3  = 4'b0000;

        //           rst   req      grant    id    busy
        tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[6]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[7]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[11] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[12] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[13] = '{1'b1, 4'b1110, 4'b0000, 2'd0, 1'b1};
        tbl[14] = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1};
        tbl[15] = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1};
        tbl[16] = '{1'b1, 4'b1101, 4'b0000, 2'd0, 1'b1};
        tbl[17] = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1};
        tbl[18] = '{1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1};
        tbl[19] = '{1'b1, 4'b1011, 4'b0000, 2'd0, 1'b1};
        tbl[20] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1};
        tbl[21] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1};
        tbl[22] = '{1'b1, 4'b0111, 4'b0000, 2'd0, 1'b1};
        tbl[23] = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[24] = '{1'b1, 4'b1110, 4'b0000, 2'd0, 1'b1};
        tbl[25] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[26] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1};
        tbl[27] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};

        for (int i = 0; i < 28; i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].req;
            tick();
            chk($sformatf("v%0d.grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("v%0d.owner", i), 32'(oid), 32'(tbl[i].id));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
            if (tbl[i].g != 4'b0000)
                chk($sformatf("v%0d.bus", i), bus_out, dv[tbl[i].id]);
            else
                chk_z($sformatf("v%0d.bus", i), bus_out);
        end

        // Reset in the middle of a tenure.
        req = 4'b0010;
        tick();
        chk("mid.grant", 32'(grant), 32'h2);
        chk("mid.bus", bus_out, 32'h12345678);
        tick();
        reset = 1'b0;
        req   = 4'b0011;
        tick();
        chk("mid.rst_grant", 32'(grant), 32'h0);
        chk("mid.rst_busy", 32'(busy), 32'h0);
        chk("mid.rst_owner", 32'(oid), 32'h0);
        chk_z("mid.rst_bus", bus_out);
        reset = 1'b1;
        tick();
        chk("mid.ch0_first", 32'(grant), 32'h1);
        chk("mid.ch0_bus", bus_out, dv[0]);
        req = 4'b0000;
        tick();
        tick();

        // Three-cycle turnaround with release and request on one edge.
        req3 = 4'b0001;
        tick();
        chk("t3.grant0", 32'(grant3), 32'h1);
        req3 = 4'b1000;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("t3.gap%0d", c), 32'(grant3), 32'h0);
            chk($sformatf("t3.gapbusy%0d", c), 32'(busy3), 32'h1);
            chk_z($sformatf("t3.gapbus%0d", c), bus_out3);
        end
        tick();
        chk("t3.grant3", 32'(grant3), 32'h8);
        chk("t3.owner3", 32'(oid3), 32'h3);
        chk("t3.bus3", bus_out3, dv[3]);
        req3 = 4'b0000;
        tick();
        tick();
        tick();
        chk("t3.busy_last_gap", 32'(busy3), 32'h1);
        tick();
        chk("t3.idle", 32'(busy3), 32'h0);

`ifdef TRI_ARB_TIMEOUT_EN
        // Tenure limit of 4 cycles when another channel waits.
        req = 4'b0001;
        tick();
        chk("to.grant0", 32'(grant), 32'h1);
        req = 4'b0011;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("to.hold%0d", c), 32'(grant), 32'h1);
        end
        tick();
        chk("to.forced", 32'(grant), 32'h0);
        tick();
        chk("to.grant1", 32'(grant), 32'h2);
        req = 4'b0001;
        tick();
        tick();
        chk("to.back0", 32'(grant), 32'h1);
        for (int c = 0; c < 24; c++) begin
            tick();
            chk($sformatf("to.alone%0d", c), 32'(grant), 32'h1);
        end
        req = 4'b0000;
        tick();
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Parametrised, registered successor to the plain 32-bit tri-state buffer.
- Arbitrates NUM_CH channels onto one shared WIDTH-bit tri-state bus. Grant is round-robin.
- Exactly one channel's output enable is active at a time, and a guaranteed all-Z turnaround gap separates owners.
- Sits between the register-file/memory/IO drivers and the shared processor data bus.

Parameters:
- WIDTH, 32: data bits per channel and on the bus.
- NUM_CH, 4: number of requesting channels (2..16).
- TURN_CYCLES, 1: all-Z cycles inserted between owners (1..7).
- MAX_BURST, 16: tenure limit in cycles, used only when TRI_ARB_TIMEOUT_EN is defined (1..255).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low; asserted when 0 at a rising edge.
- req  input  NUM_CH  per-channel bus request; level, held for the whole tenure.
- data_in  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- grant  output  NUM_CH  registered, one-hot or zero; current bus owner.
- bus_out  output  WIDTH  data_in of the owner when granted, else all bits 1'bz.
- bus_busy  output  1  registered; 1 in OWN and TURN.
- owner_id  output  $clog2(NUM_CH)  encoded index of the owner; 0 when grant==0.

Behaviour:
- Reset, synchronous, active-low, at any state:
  - next state is IDLE; grant=0; owner_id=0; bus_busy=0; bus_out all Z.
  - Turnaround counter = 0; round-robin pointer = NUM_CH-1, so channel 0 has first priority.
  - Applies mid-tenure; no extra turnaround cycle after reset.
- bus_out path:
  - Per-bit tri-state: bus_out[i] = (|grant) ? data_in[owner][i] : 1'bz.
  - Data is combinational from data_in; the enable is registered only.
- States:
  - IDLE: if |req at the edge, OWN next with the winner granted; else stay IDLE.
  - OWN:
    - If req[owner] is still 1, stay OWN with the grant unchanged.
    - If req[owner]==0, go to TURN: grant=0, counter=TURN_CYCLES-1.
  - TURN:
    - If counter!=0, decrement and stay TURN.
    - If counter==0 and |req, go straight to OWN with the new winner.
    - If counter==0 and no req, go to IDLE.
- Latency:
  - req rising in IDLE at edge t gives grant at edge t+1, i.e. visible one cycle after sampling.
  - Owner release at edge t: bus is Z for exactly TURN_CYCLES cycles, then the next grant.
- Round-robin:
  - Search starts at pointer+1 mod NUM_CH; the first asserted req wins.
  - The pointer is loaded with the winner index on each grant.
  - The same channel may win consecutively only if no other channel requests.
- Simultaneous events:
  - Requests from other channels during OWN are ignored until release. There is no preemption, except on timeout.
  - A req dropped during TURN simply does not compete.
  - Owner release and a new request on the same edge: the release is honoured and the request competes at the end of TURN.
- Invariants: $onehot0(grant) every cycle; grant never changes OWN→OWN directly to a different channel.
- Width rules: owner_id is zero-extended; MAX_BURST counter width is $clog2(MAX_BURST+1).

Optional Feature:
- Macro: TRI_ARB_TIMEOUT_EN.
- Defined:
  - A tenure counter increments each OWN cycle.
  - When it reaches MAX_BURST and any other channel requests, the bus is forced to TURN even with req[owner]=1.
  - The pointer advances past the owner, so the owner loses priority.
  - If no other channel requests, the tenure continues and the counter saturates.
  - The counter clears on entry to OWN.
- Undefined: no counter; tenure is unbounded; the MAX_BURST parameter is ignored.

Decomposition:
- Package tri_bus_pkg holds:
  - state enum IDLE/OWN/TURN (2 bits);
  - localparam ID_W = $clog2(NUM_CH) via function;
  - function rr_pick(req, ptr) returning the winner index and a found flag.
- Sub-module tri_buffer_n (WIDTH parameter): purely combinational per-bit tri-state, instanced once with oe = |grant and in = the muxed owner data.
- All arbitration and counters stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 -> grant=0, bus_out=32'hzzzzzzzz, bus_busy=0; release -> next cycle grant=4'b0001.
- Single owner: req[2]=1, data_in ch2=32'hDEADBEEF -> grant=4'b0100 after 1 cycle, bus_out=32'hDEADBEEF, owner_id=2; drop req[2] -> bus_out all Z for exactly TURN_CYCLES=1 cycle, then IDLE.
- Round-robin: req=4'b1111 constant, each owner drops req for one cycle after 2 cycles of ownership -> grant order 0,1,2,3,0, with one Z cycle between each.
- Mid-tenure reset: ch1 owning with 32'h12345678 driven, reset=0 for one edge -> next cycle grant=0 and Z, pointer=3; release with req[1]=1 and req[0]=1 -> ch0 granted first.
- TURN_CYCLES=3 instance: ch0 releases at edge t, ch3 requests at t -> bus Z during cycles t+1..t+3, grant=4'b1000 at t+4.
- TRI_ARB_TIMEOUT_EN, MAX_BURST=4: ch0 holds req, ch1 requests -> ch0 forced off after 4 cycles, TURN, then ch1 granted; with ch1 idle, ch0 keeps the bus for 20+ cycles.
